// File: rtl/hwag_spi_slave_rx.sv
// rtl/hwag_spi_slave_rx.sv - SPI mode-0 slave receiver with TX shifter and optional running CRC8.
// Define HWAG_SPI_CRC_EN to build the CRC8 register; otherwise spi_crc_rx_out is tied to 0x00.
module hwag_spi_slave_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  input  logic [7:0] spi_tx_byte,
  output logic       spi_miso,
  output logic       spi_ss,
  output logic       spi_rx,
  output logic [7:0] spi_bus_out,
  output logic [7:0] spi_crc_rx_out
);

  logic       sck_meta_q, sck_sync_q, sck_dly_q;
  logic       mosi_meta_q, mosi_sync_q;
  logic       ss_meta_q, ss_sync_q, ss_dly_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q;
  logic [7:0] rx_byte_d;
  logic [7:0] bus_out_q;
  logic       rx_q;
  logic       tx_load_q;
  logic [7:0] tx_shift_q;
  logic       sck_rise, sck_fall, ss_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_dly_q    <= 1'b0;
    end else begin
      sck_meta_q  <= spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_dly_q   <= sck_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      ss_meta_q   <= spi_ss_n;
      ss_sync_q   <= ss_meta_q;
      ss_dly_q    <= ss_sync_q;
    end
  end

  assign sck_rise = sck_sync_q & ~sck_dly_q;
  assign sck_fall = ~sck_sync_q & sck_dly_q;
  assign ss_fall  = ss_dly_q & ~ss_sync_q;

  // The eighth bit never needs storing: it completes the byte straight into spi_bus_out.
  assign rx_byte_d = {rx_shift_q, mosi_sync_q};
  assign bit_cnt_d = bit_cnt_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      bus_out_q  <= 8'h00;
      rx_q       <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_shift_q <= 8'h00;
    end else begin
      rx_q      <= 1'b0;
      tx_load_q <= rx_q;
      if (ss_sync_q) begin
        bit_cnt_q  <= 3'd0;
        rx_shift_q <= 7'd0;
        tx_shift_q <= 8'h00;
      end else begin
        if (sck_rise) begin
          rx_shift_q <= rx_byte_d[6:0];
          bit_cnt_q  <= bit_cnt_d;
          if (bit_cnt_q == 3'd7) begin
            bus_out_q <= rx_byte_d;
            rx_q      <= 1'b1;
          end
        end
        // The fall after the eighth rise belongs to the freshly loaded byte, so it must not shift.
        if (ss_fall || tx_load_q) begin
          tx_shift_q <= spi_tx_byte;
        end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_ss      = ss_sync_q;
  assign spi_rx      = rx_q;
  assign spi_bus_out = bus_out_q;
  assign spi_miso    = ~ss_sync_q & tx_shift_q[7];

`ifdef HWAG_SPI_CRC_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc8_byte(crc_q, bus_out_q);
  end

  // Updated at the end of the strobe cycle so the strobe sees only the earlier bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else if (ss_sync_q) begin
      crc_q <= 8'h00;
    end else if (rx_q) begin
      crc_q <= crc_d;
    end
  end

  assign spi_crc_rx_out = crc_q;
`else
  assign spi_crc_rx_out = 8'h00;
`endif

endmodule

// File: tb/tb_hwag_spi_slave_rx.sv
// tb/tb_hwag_spi_slave_rx.sv - scoreboard bench for hwag_spi_slave_rx with a bit-level SPI master.
// Expected CRC follows HWAG_SPI_CRC_EN the same way as the design build.
module tb_hwag_spi_slave_rx;

`ifdef HWAG_SPI_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic [7:0] spi_tx_byte = 8'h00;
  logic       spi_miso, spi_ss, spi_rx;
  logic [7:0] spi_bus_out, spi_crc_rx_out;

  hwag_spi_slave_rx dut (
    .clk(clk),
    .rst(rst),
    .spi_sck(spi_sck),
    .spi_mosi(spi_mosi),
    .spi_ss_n(spi_ss_n),
    .spi_tx_byte(spi_tx_byte),
    .spi_miso(spi_miso),
    .spi_ss(spi_ss),
    .spi_rx(spi_rx),
    .spi_bus_out(spi_bus_out),
    .spi_crc_rx_out(spi_crc_rx_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] crc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] frm_data[$];
  logic [7:0] frm_tx[$];
  logic [7:0] last_bus = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of message(x) * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_of(input logic [7:0] msg[$], input int n);
    logic [8:0] r;
    r = 9'd0;
    for (int k = 0; k < n + 1; k++) begin
      for (int j = 7; j >= 0; j--) begin
        r = {r[7:0], (k < n) ? msg[k][j] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_bus = 8'h00;
    end else if (spi_rx) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got strobe with byte %02h, expected no strobe at %0t", spi_bus_out, $time);
      end else begin
        e = exp_q.pop_front();
        check8("rx_byte", spi_bus_out, e.data);
        check8("rx_crc", spi_crc_rx_out, e.crc);
        last_bus = e.data;
      end
    end else begin
      check8("bus_hold", spi_bus_out, last_bus);
    end
  end

  task automatic spi_begin(input logic [7:0] tx0);
    @(negedge clk);
    spi_tx_byte = tx0;
    spi_ss_n = 1'b0;
    frame_q.delete();
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] b, input logic [7:0] tx_now,
                          input logic [7:0] tx_next, input int nbits);
    logic [7:0] miso_b;
    exp_t e;
    miso_b = 8'h00;
    if (nbits == 8) begin
      e.data = b;
      e.crc  = CRC_EN ? crc_of(frame_q, frame_q.size()) : 8'h00;
      exp_q.push_back(e);
      frame_q.push_back(b);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      miso_b = {miso_b[6:0], spi_miso};
      spi_sck = 1'b1;
      if (i == 7) spi_tx_byte = tx_next;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    if (nbits == 8) check8("miso_byte", miso_b, tx_now);
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input bit check_crc, input logic [7:0] exp_crc);
    int n;
    n = frm_data.size();
    spi_begin(frm_tx[0]);
    for (int k = 0; k < n; k++) begin
      spi_xfer(frm_data[k], frm_tx[k], (k + 1 < n) ? frm_tx[k+1] : 8'h00, 8);
    end
    repeat (2) @(negedge clk);
    if (check_crc) check8("crc_final", spi_crc_rx_out, CRC_EN ? exp_crc : 8'h00);
    spi_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    check8({tag, "_ss"}, {7'd0, spi_ss}, 8'h01);
    check8({tag, "_rx"}, {7'd0, spi_rx}, 8'h00);
    check8({tag, "_bus"}, spi_bus_out, 8'h00);
    check8({tag, "_crc"}, spi_crc_rx_out, 8'h00);
    check8({tag, "_miso"}, {7'd0, spi_miso}, 8'h00);
  endtask

  initial begin
    logic [7:0] six[$];
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    frm_data = '{8'hA5};
    frm_tx   = '{8'($urandom)};
    send_frame(1'b0, 8'h00);

    frm_data = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    frm_tx.delete();
    for (int k = 0; k < 9; k++) frm_tx.push_back(8'($urandom));
    send_frame(1'b1, 8'hF4);

    six = '{8'h01, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    frm_data = six;
    frm_data.push_back(crc_of(six, 6));
    frm_tx.delete();
    for (int k = 0; k < 7; k++) frm_tx.push_back(8'($urandom));
    send_frame(1'b1, 8'h00);

    spi_begin(8'($urandom));
    spi_xfer(8'hFF, 8'h00, 8'h00, 5);
    spi_end();
    frm_data = '{8'h3C};
    frm_tx   = '{8'($urandom)};
    send_frame(1'b0, 8'h00);

    frm_data = '{8'($urandom), 8'($urandom)};
    frm_tx   = '{8'h96, 8'h96};
    send_frame(1'b0, 8'h00);

    spi_begin(8'($urandom));
    spi_xfer(8'h5A, 8'h00, 8'h00, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge clk);
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    frm_data = '{8'h11};
    frm_tx   = '{8'($urandom)};
    send_frame(1'b0, 8'h00);

    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(1, 4);
      frm_data.delete();
      frm_tx.delete();
      for (int k = 0; k < len; k++) begin
        frm_data.push_back(8'($urandom));
        frm_tx.push_back(8'($urandom));
      end
      send_frame(1'b1, crc_of(frm_data, len));
    end

    repeat (20) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_strobes: got %0d outstanding bytes, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
